// File: rtl/pipe_r_ser.sv
`default_nettype none
// ============================================================================
// Module   : pipe_r_ser
// Purpose  : Captures one 32-point frame of W-bit signed real samples in
//            parallel and replays it as a ready/valid serial stream, one
//            sample per accepted beat. Back-to-back frames are accepted on
//            the final beat, so consecutive frames stream with no bubble.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 rising-edge clock
//   arstb               asynchronous reset, active-low
//   rstb                synchronous clear, active-low
//   in_valid            parallel frame present on d_r_0..d_r_31
//   in_ready            frame can be captured this cycle
//   d_r_0 .. d_r_31     W-bit signed samples of one frame
//   out_valid           out_data holds a valid sample
//   out_ready           downstream accepts the sample
//   out_data            current serial sample (W-bit signed)
//   out_idx             source index k of out_data
//   out_last            current sample is beat 31 of the frame
//   frames_done         modulo-256 count of completely sent frames
// Configuration
//   PIPE_R_SER_BITREV_EN  defined: beat cnt reads entry bitrev5(cnt)
//                         (bit-reversed to natural order conversion);
//                         undefined: beat cnt reads entry cnt.
// ============================================================================
module pipe_r_ser #(
   parameter int W = 9
) (
   input  logic                clk,
   input  logic                arstb,
   input  logic                rstb,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] d_r_0,
   input  logic signed [W-1:0] d_r_1,
   input  logic signed [W-1:0] d_r_2,
   input  logic signed [W-1:0] d_r_3,
   input  logic signed [W-1:0] d_r_4,
   input  logic signed [W-1:0] d_r_5,
   input  logic signed [W-1:0] d_r_6,
   input  logic signed [W-1:0] d_r_7,
   input  logic signed [W-1:0] d_r_8,
   input  logic signed [W-1:0] d_r_9,
   input  logic signed [W-1:0] d_r_10,
   input  logic signed [W-1:0] d_r_11,
   input  logic signed [W-1:0] d_r_12,
   input  logic signed [W-1:0] d_r_13,
   input  logic signed [W-1:0] d_r_14,
   input  logic signed [W-1:0] d_r_15,
   input  logic signed [W-1:0] d_r_16,
   input  logic signed [W-1:0] d_r_17,
   input  logic signed [W-1:0] d_r_18,
   input  logic signed [W-1:0] d_r_19,
   input  logic signed [W-1:0] d_r_20,
   input  logic signed [W-1:0] d_r_21,
   input  logic signed [W-1:0] d_r_22,
   input  logic signed [W-1:0] d_r_23,
   input  logic signed [W-1:0] d_r_24,
   input  logic signed [W-1:0] d_r_25,
   input  logic signed [W-1:0] d_r_26,
   input  logic signed [W-1:0] d_r_27,
   input  logic signed [W-1:0] d_r_28,
   input  logic signed [W-1:0] d_r_29,
   input  logic signed [W-1:0] d_r_30,
   input  logic signed [W-1:0] d_r_31,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_data,
   output logic [4:0]          out_idx,
   output logic                out_last,
   output logic [7:0]          frames_done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic signed [W-1:0] buf_q [32];
   logic signed [W-1:0] buf_d [32];
   logic signed [W-1:0] out_data_q, out_data_d;
   logic [4:0]          out_idx_q, out_idx_d;
   logic                out_last_q, out_last_d;
   logic [7:0]          frames_done_q, frames_done_d;

   logic signed [W-1:0] din [32];
   logic [4:0]          cnt_nxt;
   logic                beat_done;
   logic                frame_end;
   logic                accept;
   logic                capture;

   assign din[0]  = d_r_0;
   assign din[1]  = d_r_1;
   assign din[2]  = d_r_2;
   assign din[3]  = d_r_3;
   assign din[4]  = d_r_4;
   assign din[5]  = d_r_5;
   assign din[6]  = d_r_6;
   assign din[7]  = d_r_7;
   assign din[8]  = d_r_8;
   assign din[9]  = d_r_9;
   assign din[10] = d_r_10;
   assign din[11] = d_r_11;
   assign din[12] = d_r_12;
   assign din[13] = d_r_13;
   assign din[14] = d_r_14;
   assign din[15] = d_r_15;
   assign din[16] = d_r_16;
   assign din[17] = d_r_17;
   assign din[18] = d_r_18;
   assign din[19] = d_r_19;
   assign din[20] = d_r_20;
   assign din[21] = d_r_21;
   assign din[22] = d_r_22;
   assign din[23] = d_r_23;
   assign din[24] = d_r_24;
   assign din[25] = d_r_25;
   assign din[26] = d_r_26;
   assign din[27] = d_r_27;
   assign din[28] = d_r_28;
   assign din[29] = d_r_29;
   assign din[30] = d_r_30;
   assign din[31] = d_r_31;

   // Buffer entry read on beat c.
   function automatic logic [4:0] rd_sel(input logic [4:0] c);
`ifdef PIPE_R_SER_BITREV_EN
      return {c[0], c[1], c[2], c[3], c[4]};
`else
      return c;
`endif
   endfunction

   assign out_valid   = (state_q == SEND);
   assign out_data    = out_data_q;
   assign out_idx     = out_idx_q;
   assign out_last    = out_last_q;
   assign frames_done = frames_done_q;

   // The final beat of a frame frees the buffer in the same cycle, so the
   // next frame may be captured while beat 31 is being accepted.
   assign beat_done = (state_q == SEND) && out_ready;
   assign frame_end = beat_done && (cnt_q == 5'd31);
   assign accept    = (state_q == IDLE) || frame_end;
   assign capture   = in_valid && accept;
   assign in_ready  = accept && rstb && arstb;
   assign cnt_nxt   = cnt_q + 5'd1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      buf_d         = buf_q;
      out_data_d    = out_data_q;
      out_idx_d     = out_idx_q;
      out_last_d    = out_last_q;
      frames_done_d = frames_done_q;

      if (!rstb) begin
         state_d       = IDLE;
         cnt_d         = '0;
         out_data_d    = '0;
         out_idx_d     = '0;
         out_last_d    = 1'b0;
         frames_done_d = '0;
         for (int i = 0; i < 32; i++) begin
            buf_d[i] = '0;
         end
      end else begin
         if (frame_end) begin
            frames_done_d = frames_done_q + 8'd1;
         end
         if (capture) begin
            // First sample is taken straight from the inputs so it is
            // presented the cycle after capture.
            buf_d      = din;
            state_d    = SEND;
            cnt_d      = '0;
            out_data_d = din[rd_sel(5'd0)];
            out_idx_d  = rd_sel(5'd0);
            out_last_d = 1'b0;
         end else if (beat_done) begin
            if (cnt_q == 5'd31) begin
               state_d    = IDLE;
               cnt_d      = '0;
               out_idx_d  = rd_sel(5'd0);
               out_last_d = 1'b0;
            end else begin
               cnt_d      = cnt_nxt;
               out_data_d = buf_q[rd_sel(cnt_nxt)];
               out_idx_d  = rd_sel(cnt_nxt);
               out_last_d = (cnt_nxt == 5'd31);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         out_data_q    <= '0;
         out_idx_q     <= '0;
         out_last_q    <= 1'b0;
         frames_done_q <= '0;
         for (int i = 0; i < 32; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         out_data_q    <= out_data_d;
         out_idx_q     <= out_idx_d;
         out_last_q    <= out_last_d;
         frames_done_q <= frames_done_d;
         for (int i = 0; i < 32; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_r_ser.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_r_ser
// Purpose  : Self-checking bench for pipe_r_ser: directed vector table,
//            randomized traffic against a frame-level reference model,
//            back-to-back frames, frames_done wrap and async reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_r_ser;

   localparam int W = 9;

   logic                clk = 1'b0;
   logic                arstb = 1'b0;
   logic                rstb = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] d_r [32];
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] out_data;
   logic [4:0]          out_idx;
   logic                out_last;
   logic [7:0]          frames_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_r_ser #(.W(W)) dut (
      .clk(clk), .arstb(arstb), .rstb(rstb),
      .in_valid(in_valid), .in_ready(in_ready),
      .d_r_0(d_r[0]),   .d_r_1(d_r[1]),   .d_r_2(d_r[2]),   .d_r_3(d_r[3]),
      .d_r_4(d_r[4]),   .d_r_5(d_r[5]),   .d_r_6(d_r[6]),   .d_r_7(d_r[7]),
      .d_r_8(d_r[8]),   .d_r_9(d_r[9]),   .d_r_10(d_r[10]), .d_r_11(d_r[11]),
      .d_r_12(d_r[12]), .d_r_13(d_r[13]), .d_r_14(d_r[14]), .d_r_15(d_r[15]),
      .d_r_16(d_r[16]), .d_r_17(d_r[17]), .d_r_18(d_r[18]), .d_r_19(d_r[19]),
      .d_r_20(d_r[20]), .d_r_21(d_r[21]), .d_r_22(d_r[22]), .d_r_23(d_r[23]),
      .d_r_24(d_r[24]), .d_r_25(d_r[25]), .d_r_26(d_r[26]), .d_r_27(d_r[27]),
      .d_r_28(d_r[28]), .d_r_29(d_r[29]), .d_r_30(d_r[30]), .d_r_31(d_r[31]),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .frames_done(frames_done)
   );

   // ------------------------------------------------------------------
   // Reference model: the held frame, how many of its beats were sent,
   // and the completed-frame count.
   // ------------------------------------------------------------------
   logic signed [W-1:0] m_frame [32];
   bit                  m_busy;
   int                  m_p;
   int                  m_fd;
   bit                  m_zero;

   function automatic int ord(input int p);
`ifdef PIPE_R_SER_BITREV_EN
      int r = 0;
      for (int b = 0; b < 5; b++) if (p[b]) r |= (1 << (4 - b));
      return r;
`else
      return p;
`endif
   endfunction

   function automatic bit exp_in_ready();
      return arstb && rstb && (!m_busy || (m_p == 31 && out_ready));
   endfunction

   task automatic model_reset();
      m_busy = 0; m_p = 0; m_fd = 0; m_zero = 1;
      for (int k = 0; k < 32; k++) m_frame[k] = '0;
   endtask

   task automatic model_edge();
      bit ir;
      ir = exp_in_ready();
      if (!rstb) begin
         model_reset();
      end else begin
         if (m_busy && out_ready) begin
            if (m_p == 31) begin
               m_fd   = (m_fd + 1) % 256;
               m_busy = 0;
               m_p    = 0;
            end else begin
               m_p++;
            end
         end
         if (ir && in_valid) begin
            for (int k = 0; k < 32; k++) m_frame[k] = d_r[k];
            m_busy = 1; m_p = 0; m_zero = 0;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, $signed(act), $signed(exp), $time);
      end
   endtask

   task automatic check_model();
      chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_busy));
      chk("frames_done", 32'(frames_done), 32'(m_fd));
      if (m_busy) begin
         chk("out_data", 32'(out_data), 32'(m_frame[ord(m_p)]));
         chk("out_idx", 32'(out_idx), 32'(ord(m_p)));
         chk("out_last", 32'(out_last), 32'(m_p == 31));
      end else begin
         chk("out_last_idle", 32'(out_last), 32'd0);
         if (m_zero) begin
            chk("out_data_clr", 32'(out_data), 32'd0);
            chk("out_idx_clr", 32'(out_idx), 32'd0);
         end
      end
   endtask

   // One clock: compare at the falling edge, advance model at the rising
   // edge, return just after it so the caller can drive new inputs.
   task automatic cycle();
      @(negedge clk);
      check_model();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic hard_reset();
      arstb = 1'b0;
      rstb = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      arstb = 1'b1;
   endtask

   task automatic load_ramp(input int base);
      for (int k = 0; k < 32; k++) d_r[k] = W'(base + k);
   endtask

   typedef struct {
      logic iv, ordy, rs;
      logic ev, er;
      int   beat;   // -1: idle with cleared outputs
      int   fd;
   } vec_t;

   vec_t vt [11];

   initial begin
      vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0};
      vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  0, 0};
      vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  0, 0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0};
      vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  1, 0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  2, 0};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0};
      vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0, 0};
      vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  1, 0};

      load_ramp(0);
      hard_reset();

      // Directed table: frame d_r_k = k so sample value equals its index.
      for (int i = 0; i < 11; i++) begin
         in_valid = vt[i].iv; out_ready = vt[i].ordy; rstb = vt[i].rs;
         @(negedge clk);
         chk("t_out_valid", 32'(out_valid), 32'(vt[i].ev));
         chk("t_in_ready", 32'(in_ready), 32'(vt[i].er));
         chk("t_frames_done", 32'(frames_done), 32'(vt[i].fd));
         if (vt[i].beat < 0) begin
            chk("t_data_clr", 32'(out_data), 32'd0);
            chk("t_idx_clr", 32'(out_idx), 32'd0);
            chk("t_last_clr", 32'(out_last), 32'd0);
         end else begin
            chk("t_data", 32'(out_data), 32'(ord(vt[i].beat)));
            chk("t_idx", 32'(out_idx), 32'(ord(vt[i].beat)));
         end
         @(posedge clk); #1;
      end
      rstb = 1'b1;

      // Full frame with out_ready held high, then idle afterwards.
      hard_reset();
      load_ramp(0);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 34; i++) cycle();

      // Stall pattern 1,0,1,0 on a negative ramp.
      hard_reset();
      load_ramp(-256);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 70; i++) begin
         out_ready = (i % 2 == 0);
         if (i == 3) load_ramp(50);   // input changes must not leak in
         cycle();
      end

      // Two frames back-to-back with in_valid held high.
      hard_reset();
      load_ramp(0);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      load_ramp(100);
      begin
         int nvalid = 0;
         int b0_at = -1;
         for (int i = 0; i < 64; i++) begin
            if (i == 32) in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) nvalid++;
            if (i == 32) b0_at = int'(out_data);
            check_model();
            @(posedge clk); model_edge(); #1;
         end
         chk("b2b_valid_beats", 32'(nvalid), 32'd64);
         chk("b2b_first_b", 32'(b0_at), 32'd100);
         @(negedge clk);
         chk("b2b_frames_done", 32'(frames_done), 32'd2);
         @(posedge clk); #1;
      end

      // rstb pulse in the middle of a frame.
      hard_reset();
      load_ramp(0);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      rstb = 1'b0;
      cycle();
      rstb = 1'b1;
      cycle();
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) cycle();

      // Randomized traffic against the model.
      hard_reset();
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         rstb      = ($urandom_range(0, 199) != 0);
         for (int k = 0; k < 32; k++) d_r[k] = W'($urandom);
         cycle();
      end
      rstb = 1'b1;

      // 256 frames to wrap frames_done, then async reset mid-frame.
      hard_reset();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 256 * 32 + 10; i++) begin
         if (i % 32 == 1) for (int k = 0; k < 32; k++) d_r[k] = W'($urandom);
         cycle();
      end
      @(negedge clk);
      chk("wrap_frames_done", 32'(frames_done), 32'd0);
      chk("wrap_busy", 32'(out_valid), 32'd1);
      #2;
      arstb = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", 32'(out_data), 32'd0);
      chk("arst_out_idx", 32'(out_idx), 32'd0);
      chk("arst_out_last", 32'(out_last), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      #1;
      arstb = 1'b1;
      model_reset();
      @(posedge clk); model_edge(); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
